// File: rtl/load_store_unit.sv
// Load/store stage: turns an ALU-computed effective address into one bus
// transaction with byte strobes, lane replication and load-data extension.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] load_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_wstrobe,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [31:0] LIMIT = TIMEOUT - 1;

  logic [1:0]  state;
  logic        errFlag;
  logic [31:0] count;
  logic [1:0]  laneSel;
  logic [2:0]  sizeSel;
  logic        loadKind;

  logic        badFunct3;
  logic        misaligned;
  logic [3:0]  strobe;
  logic [31:0] wdata;
  logic [31:0] lane;
  logic [31:0] extended;
  logic        expired;

  // Request decode is done on the raw inputs so illegal requests finish without a bus access.
  always_comb begin
    badFunct3 = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: badFunct3 = 1'b0;
      3'b100, 3'b101:         badFunct3 = !is_load;
      default:                badFunct3 = 1'b1;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                 ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
    strobe = 4'b1111;
    wdata  = store_data;
    case (funct3[1:0])
      2'b00: begin
        strobe = 4'b0001 << address[1:0];
        wdata  = {4{store_data[7:0]}};
      end
      2'b01: begin
        strobe = 4'b0011 << address[1:0];
        wdata  = {2{store_data[15:0]}};
      end
      default: begin
        strobe = 4'b1111;
        wdata  = store_data;
      end
    endcase
  end

  always_comb begin
    lane     = mem_rdata >> {laneSel, 3'b000};
    extended = lane;
    case (sizeSel)
      3'b000:  extended = {{24{lane[7]}}, lane[7:0]};
      3'b001:  extended = {{16{lane[15]}}, lane[15:0]};
      3'b100:  extended = {24'h000000, lane[7:0]};
      3'b101:  extended = {16'h0000, lane[15:0]};
      default: extended = lane;
    endcase
  end

  assign expired = (TIMEOUT != 0) && (count == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      errFlag     <= 1'b0;
      count       <= '0;
      laneSel     <= 2'b00;
      sizeSel     <= 3'b000;
      loadKind    <= 1'b0;
      load_data   <= '0;
      mem_address <= '0;
      mem_wstrobe <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          errFlag <= 1'b0;
          if (start) begin
            if (!is_load && !is_store) begin
              state <= DONE;
            end else if (badFunct3 || misaligned) begin
              state   <= DONE;
              errFlag <= 1'b1;
            end else begin
              state       <= REQ;
              count       <= '0;
              laneSel     <= address[1:0];
              sizeSel     <= funct3;
              loadKind    <= is_load;
              mem_address <= {address[31:2], 2'b00};
              mem_wstrobe <= is_load ? 4'b0000 : strobe;
              mem_wdata   <= wdata;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (loadKind) load_data <= extended;
            state   <= DONE;
            errFlag <= 1'b0;
          end else if (expired) begin
            state   <= DONE;
            errFlag <= 1'b1;
          end else begin
            count <= count + 32'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          errFlag <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == REQ) || (state == DONE);
  assign done      = (state == DONE);
  assign error     = done && errFlag;
  assign mem_valid = (state == REQ);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, wait states, error paths,
// timeout and mid-request reset, each with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] load_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [3:0]  mem_wstrobe;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .address(address), .store_data(store_data), .busy(busy),
    .done(done), .error(error), .load_data(load_data), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_address(mem_address), .mem_wstrobe(mem_wstrobe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; after it returns we are sampling cycle N+1.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; address = a; store_data = d;
    @(negedge clk);
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    address = '0; store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if ({busy, done, error, mem_valid} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, error, mem_valid}); end
    vectors++; if (mem_wstrobe !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_strobe: got %b expected 0000", mem_wstrobe); end
    vectors++; if ({load_data, mem_address, mem_wdata} !== 96'd0) begin miscompares++; $display("[TB] FAIL reset_regs: got %h %h %h expected zeros", load_data, mem_address, mem_wdata); end
  endtask

  task automatic test_loads();
    logic [2:0]  f  [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] a  [5] = '{32'h100, 32'h203, 32'h203, 32'h202, 32'h202};
    logic [31:0] rd [5] = '{32'hDEADBEEF, 32'h80FF0000, 32'h80FF0000, 32'h80010000, 32'h80010000};
    logic [31:0] ex [5] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b0, f[i], a[i], 32'h0);
      vectors++; if (mem_valid !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL load%0d_valid: got valid=%b done=%b expected 1 0", i, mem_valid, done); end
      vectors++; if (mem_address !== {a[i][31:2], 2'b00} || mem_wstrobe !== 4'b0000) begin miscompares++; $display("[TB] FAIL load%0d_bus: got %h/%b expected %h/0000", i, mem_address, mem_wstrobe, {a[i][31:2], 2'b00}); end
      mem_ready = 1'b1; mem_rdata = rd[i];
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = 32'h0;
      vectors++; if ({done, error, busy, mem_valid} !== 4'b1010) begin miscompares++; $display("[TB] FAIL load%0d_done: got %b expected 1010", i, {done, error, busy, mem_valid}); end
      vectors++; if (load_data !== ex[i]) begin miscompares++; $display("[TB] FAIL load%0d_data: got %h expected %h", i, load_data, ex[i]); end
      @(negedge clk);
      vectors++; if ({done, busy} !== 2'b00) begin miscompares++; $display("[TB] FAIL load%0d_idle: got %b expected 00", i, {done, busy}); end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f  [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] a  [3] = '{32'h11, 32'h12, 32'h20};
    logic [31:0] ma [3] = '{32'h10, 32'h10, 32'h20};
    logic [3:0]  sb [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] wd [3] = '{32'hABABABAB, 32'h56AB56AB, 32'h123456AB};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, f[i], a[i], 32'h123456AB);
      vectors++; if (mem_valid !== 1'b1 || mem_address !== ma[i]) begin miscompares++; $display("[TB] FAIL store%0d_addr: got %b/%h expected 1/%h", i, mem_valid, mem_address, ma[i]); end
      vectors++; if (mem_wstrobe !== sb[i] || mem_wdata !== wd[i]) begin miscompares++; $display("[TB] FAIL store%0d_lanes: got %b/%h expected %b/%h", i, mem_wstrobe, mem_wdata, sb[i], wd[i]); end
      mem_ready = 1'b1; mem_rdata = 32'h55555555;
      @(negedge clk);
      mem_ready = 1'b0;
      vectors++; if ({done, error} !== 2'b10 || load_data !== 32'h00008001) begin miscompares++; $display("[TB] FAIL store%0d_done: got %b/%h expected 10/00008001", i, {done, error}, load_data); end
      @(negedge clk);
    end
  endtask

  task automatic test_wait_states();
    issue(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (mem_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL wait%0d_flags: got %b%b%b expected 110", i, mem_valid, busy, done); end
      vectors++; if (mem_address !== 32'h40 || mem_wstrobe !== 4'b1111 || mem_wdata !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL wait%0d_stable: got %h/%b/%h expected 00000040/1111/cafef00d", i, mem_address, mem_wstrobe, mem_wdata); end
      if (i == 1) begin
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; address = 32'h500;
      end else begin
        start = 1'b0; is_load = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; is_load = 1'b0;
    vectors++; if (mem_address !== 32'h40 || mem_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wait_ignore_start: got %h/%b expected 00000040/1", mem_address, mem_valid); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    vectors++; if ({done, error, mem_valid} !== 3'b100) begin miscompares++; $display("[TB] FAIL wait_done: got %b expected 100", {done, error, mem_valid}); end
    @(negedge clk);
    @(negedge clk);
    vectors++; if ({busy, mem_valid, done} !== 3'b000) begin miscompares++; $display("[TB] FAIL wait_no_replay: got %b expected 000", {busy, mem_valid, done}); end
  endtask

  task automatic test_errors();
    logic        ld [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        st [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
    logic [31:0] a  [5] = '{32'h102, 32'h1, 32'h100, 32'h100, 32'h100};
    logic        er [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      issue(ld[i], st[i], f[i], a[i], 32'hFFFFFFFF);
      vectors++; if ({done, error, busy, mem_valid} !== {1'b1, er[i], 2'b10}) begin miscompares++; $display("[TB] FAIL err%0d_done: got %b expected %b", i, {done, error, busy, mem_valid}, {1'b1, er[i], 2'b10}); end
      @(negedge clk);
      vectors++; if ({done, error, mem_valid} !== 3'b000 || load_data !== 32'h00008001) begin miscompares++; $display("[TB] FAIL err%0d_after: got %b/%h expected 000/00008001", i, {done, error, mem_valid}, load_data); end
    end
  endtask

  task automatic test_timeout();
    mem_rdata = 32'h77777777;
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (mem_valid !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout%0d_valid: got %b/%b expected 1/0", i, mem_valid, done); end
      @(negedge clk);
    end
    vectors++; if ({mem_valid, done, error} !== 3'b011) begin miscompares++; $display("[TB] FAIL timeout_done: got %b expected 011", {mem_valid, done, error}); end
    vectors++; if (load_data !== 32'h00008001) begin miscompares++; $display("[TB] FAIL timeout_data: got %h expected 00008001", load_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    vectors++; if (mem_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_pre: got %b expected 1", mem_valid); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if ({mem_valid, busy, done} !== 3'b000) begin miscompares++; $display("[TB] FAIL rst_mid_drop: got %b expected 000", {mem_valid, busy, done}); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if ({mem_valid, busy, done, error} !== 4'b0000 || load_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid_after: got %b/%h expected 0000/00000000", {mem_valid, busy, done, error}, load_data); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_wait_states();
    test_errors();
    test_timeout();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
